inst_fetch: RTL
===============

// Module: inst_fetch
// PURPOSE
//  Fetch stage upstream of ctrl. Holds the PC and issues req/ack reads to instruction memory.
//  Buffers the returned word in an instruction register plus a 1-entry skid buffer, and flushes on redirects.
//  Splits the current word into the opcode/func3/func7/rd/rs1/rs2 fields that feed ctrl and the register file.
//  Emits NOP (addi x0,x0,0) bubbles whenever no valid instruction is present.
// PARAMETERS
//  ADDR_W    32             width of PC / memory address
//  RESET_PC  32'h0000_0000  first fetch address after reset (bits [1:0] must be 0)
//  NOP_INST  32'h0000_0013  word driven on inst when inst_valid=0
// PORTS
//  clk          in   1       clock, all state updates on rising edge
//  rst          in   1       synchronous reset, active-high
//  imem_req     out  1       read request to instruction memory
//  imem_addr    out  ADDR_W  word-aligned read address, stable while imem_req=1 and no ack
//  imem_ack     in   1       read data valid this cycle (sampled only while imem_req=1)
//  imem_rdata   in   32      instruction word, valid with imem_ack
//  stall        in   1       decode cannot accept: hold inst/inst_pc/inst_valid
//  redirect     in   1       taken branch/jump (pc_sel not PC+4); overrides stall
//  redirect_pc  in   ADDR_W  target address; bits [1:0] forced to 0
//  inst         out  32      current instruction (NOP_INST when inst_valid=0)
//  inst_pc      out  ADDR_W  address of inst
//  inst_valid   out  1       inst holds a real fetched instruction
//  opcode       out  5       inst[6:2]
//  func3        out  3       inst[14:12]
//  func7        out  7       inst[31:25]
//  rd/rs1/rs2   out  5 each  inst[11:7] / inst[19:15] / inst[24:20]
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, pc=RESET_PC, imem_req=0, inst=NOP_INST, inst_pc=RESET_PC,
//   inst_valid=0, skid empty. Applies mid-request: req drops next cycle, pending ack ignored.
//  Field outputs are purely combinational slices of inst; NOP gives opcode=5'b00100, others 0.
//  FSM:
//   IDLE  -> FETCH unconditionally (one cycle after reset release).
//   FETCH imem_req=1 when skid empty; imem_addr=pc. On ack: word accepted and pc<=pc+4.
//         pc+4 wraps modulo 2^ADDR_W.
//   DRAIN imem_req=1 at old address until ack; data discarded; then FETCH at the redirect pc.
//  Accepted word routing:
//   - To inst if stall=0 or inst_valid=0, with inst_pc=fetch address and inst_valid=1.
//   - Else to skid; skid full deasserts imem_req (no new request).
//  stall=0 with skid full: inst<=skid, skid empties, req resumes next cycle.
//  stall=0, no ack, skid empty: inst_valid<=0 (bubble).
//  Redirect (highest priority, any state except IDLE):
//   - pc<=redirect_pc&~3, inst_valid<=0, skid cleared.
//   - If a request is outstanding without ack this cycle -> DRAIN.
//   - If ack arrives in the redirect cycle -> data discarded, stay FETCH.
//   - Redirect during DRAIN overwrites the target pc.
//  Latency:
//   - imem_req first high 2 cycles after reset release.
//   - With ack tied high: inst_valid high the cycle after the first ack, then 1 instr/cycle.
//   - First fetch after redirect issues the next cycle (or after drain).
//  Throughput: no instruction is duplicated or lost across stall/skid transitions.
// TESTING
//  1 Hold rst 2 cycles, ack=1 -> imem_req=0, inst=0x13, opcode=00100 during reset;
//    afterwards imem_addr 0x0,0x4,0x8...; inst_pc follows one cycle behind.
//  2 Ack low 3 cycles at addr 0x8, then ack with rdata=0x40B50533 -> addr held at 0x8, inst_valid=0;
//    then opcode=01100, func3=0, func7=0100000, rd=10, rs1=10, rs2=11.
//  3 Raise stall while ack=1 -> inst holds; next word lands in skid; imem_req drops.
//    Release stall -> skid word presented, order 0x10,0x14,0x18 preserved.
//  4 Ack=0 outstanding at 0x20, redirect to 0x103 -> DRAIN holds 0x20 until ack, data dropped.
//    Next req at 0x100; inst_valid=0 throughout.
//  5 redirect=1, stall=1 and ack=1 together -> skid cleared, inst_valid=0, next addr=redirect_pc.
//  6 RESET_PC=32'hFFFF_FFFC -> second fetch address 0x0.
//    rst asserted mid-request -> imem_req=0 next cycle, outputs at reset values.

Source files
------------

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage with instruction register, skid buffer and redirect drain
module inst_fetch #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [31:0]       NOP_INST = 32'h0000_0013
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_ack,
    input  logic [31:0]       i_imem_rdata,
    input  logic              i_stall,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic [31:0]       o_inst,
    output logic [ADDR_W-1:0] o_inst_pc,
    output logic              o_inst_valid,
    output logic [4:0]        o_opcode,
    output logic [2:0]        o_func3,
    output logic [6:0]        o_func7,
    output logic [4:0]        o_rd,
    output logic [4:0]        o_rs1,
    output logic [4:0]        o_rs2
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_drain_addr;
    logic [ADDR_W-1:0] r_inst_pc;
    logic [ADDR_W-1:0] r_skid_pc;
    logic [31:0]       r_inst;
    logic [31:0]       r_skid_inst;
    logic              r_inst_valid;
    logic              r_skid_valid;

    logic              w_req;
    logic              w_ack;
    logic              w_redirect;
    logic [ADDR_W-1:0] w_redirect_pc;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [31:0]       w_inst;

    // Redirect targets are always word aligned; pc+4 wraps naturally at ADDR_W bits.
    assign w_redirect_pc = i_redirect_pc & {{(ADDR_W-2){1'b1}}, 2'b00};
    assign w_pc_inc      = r_pc + ADDR_W'(4);

    // Request is held while fetching with room in the skid, and throughout a drain.
    always_comb begin
        w_req = 1'b0;
        if (r_state == S_FETCH && !r_skid_valid) begin
            w_req = 1'b1;
        end else if (r_state == S_DRAIN) begin
            w_req = 1'b1;
        end
    end

    assign w_ack      = w_req & i_imem_ack;
    assign w_redirect = i_redirect & (r_state != S_IDLE);

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: a redirect with an unanswered request must wait out the stale ack.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  w_state_next = S_FETCH;
            S_FETCH: begin
                if (w_redirect && w_req && !w_ack) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_ack) begin
                    w_state_next = S_FETCH;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Program counter and the address of the request being drained.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc         <= RESET_PC;
            r_drain_addr <= RESET_PC;
        end else begin
            if (w_redirect) begin
                r_pc <= w_redirect_pc;
            end else if (r_state == S_FETCH && w_ack) begin
                r_pc <= w_pc_inc;
            end
            if (w_redirect && r_state == S_FETCH && w_req && !w_ack) begin
                r_drain_addr <= r_pc;
            end
        end
    end

    // Instruction register and skid: route accepted words, drain skid on unstall, flush on redirect.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_inst       <= NOP_INST;
            r_inst_pc    <= RESET_PC;
            r_inst_valid <= 1'b0;
            r_skid_inst  <= NOP_INST;
            r_skid_pc    <= RESET_PC;
            r_skid_valid <= 1'b0;
        end else if (w_redirect) begin
            r_inst       <= NOP_INST;
            r_inst_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (r_state == S_FETCH) begin
            if (w_ack && (!i_stall || !r_inst_valid)) begin
                r_inst       <= i_imem_rdata;
                r_inst_pc    <= r_pc;
                r_inst_valid <= 1'b1;
            end else if (w_ack) begin
                r_skid_inst  <= i_imem_rdata;
                r_skid_pc    <= r_pc;
                r_skid_valid <= 1'b1;
            end else if (!i_stall && r_skid_valid) begin
                r_inst       <= r_skid_inst;
                r_inst_pc    <= r_skid_pc;
                r_inst_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (!i_stall) begin
                r_inst_valid <= 1'b0;
            end
        end
    end

    assign w_inst       = r_inst_valid ? r_inst : NOP_INST;
    assign o_imem_req   = w_req;
    assign o_imem_addr  = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
    assign o_inst       = w_inst;
    assign o_inst_pc    = r_inst_pc;
    assign o_inst_valid = r_inst_valid;
    assign o_opcode     = w_inst[6:2];
    assign o_func3      = w_inst[14:12];
    assign o_func7      = w_inst[31:25];
    assign o_rd         = w_inst[11:7];
    assign o_rs1        = w_inst[19:15];
    assign o_rs2        = w_inst[24:20];

endmodule
